lm_sm_expander: RTL and testbench

- Sits in the iitb_risc pipeline between the IF/ID register and the ID/RR stage. Directly consumes what instruction fetch produces.
- Passes ordinary instructions through unchanged.
- Expands each load-multiple (LM) or store-multiple (SM) instruction into a sequence of single-word LW/SW micro-instructions, one per set mask bit. Downstream stages therefore need no multi-cycle memory logic.
- Holds fetch (in_ready low) while a sequence is in progress.

---
 rtl/risc_pkg.sv | 30 +++
 rtl/lm_sm_expander_lowbit_sel.sv | 21 ++
 rtl/lm_sm_expander.sv | 156 +++++++++++++++
 tb/tb_lm_sm_expander.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared iitb_risc definitions: opcodes, instruction field positions, expander states
// and the micro-op encoder used when an LM/SM is broken into single-word accesses.
package risc_pkg;

   localparam logic [3:0] OP_LW = 4'b0100;
   localparam logic [3:0] OP_SW = 4'b0101;
   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 12;
   localparam int RA_HI   = 11;
   localparam int RA_LO   = 9;
   localparam int MASK_HI = 7;
   localparam int MASK_LO = 0;

   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } state_t;

   // Address is Ra+offset because memory is word-addressed.
   function automatic logic [15:0] make_uop(input logic       is_sm,
                                            input logic [2:0] rk,
                                            input logic [2:0] ra,
                                            input logic [2:0] offset);
      return {(is_sm ? OP_SW : OP_LW), rk, ra, 3'b000, offset};
   endfunction

endpackage

// File: rtl/lm_sm_expander_lowbit_sel.sv
// Picks the lowest set bit of a register mask: its index, a one-hot vector to clear it,
// and whether it is the only bit left.
module lowbit_sel (
   input  logic [7:0] mask,
   output logic [2:0] idx,
   output logic [7:0] clr,
   output logic       last
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
   end

   assign clr  = mask & (~mask + 8'd1);
   assign last = ((mask & ~clr) == 8'd0);

endmodule

// File: rtl/lm_sm_expander.sv
// Decode-side expander: passes ordinary instructions through and turns each LM/SM into
// a run of LW/SW micro-ops, holding fetch off while a run is in progress.
module lm_sm_expander
   import risc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   output logic        out_uop,
   output logic        out_last,
   output logic        busy
);

   state_t      state, state_nxt;
   logic [7:0]  rem_mask, rem_mask_nxt;
   logic [2:0]  base, base_nxt;
   logic        op_is_sm, op_is_sm_nxt;
   logic [15:0] seq_pc, seq_pc_nxt;
   logic [2:0]  cnt, cnt_nxt;

   logic        out_valid_nxt, out_uop_nxt, out_last_nxt;
   logic [15:0] out_instr_nxt, out_pc_nxt;

   logic        adv, accept, in_is_multi, in_is_sm;
   logic [3:0]  in_opc;
   logic [2:0]  in_ra;
   logic [7:0]  in_mask, sel_mask, sel_clr;
   logic [2:0]  sel_idx;
   logic        sel_last;

   assign in_opc      = in_instr[OPC_HI:OPC_LO];
   assign in_ra       = in_instr[RA_HI:RA_LO];
   assign in_mask     = in_instr[MASK_HI:MASK_LO];
   assign in_is_multi = (in_opc == OP_LM) || (in_opc == OP_SM);
   assign in_is_sm    = (in_opc == OP_SM);

   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n && (state == IDLE) && adv && !flush;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == SEQ);

   // One selector serves both the first micro-op (fresh mask) and the rest of the run.
   assign sel_mask = (state == SEQ) ? rem_mask : in_mask;

   lowbit_sel u_lowbit_sel (
      .mask (sel_mask),
      .idx  (sel_idx),
      .clr  (sel_clr),
      .last (sel_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (accept && in_is_multi && (in_mask != 8'd0) && !sel_last) state_nxt = SEQ;
            SEQ:  if (adv && sel_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid_nxt = out_valid;
      out_instr_nxt = out_instr;
      out_pc_nxt    = out_pc;
      out_uop_nxt   = out_uop;
      out_last_nxt  = out_last;
      rem_mask_nxt  = rem_mask;
      base_nxt      = base;
      op_is_sm_nxt  = op_is_sm;
      seq_pc_nxt    = seq_pc;
      cnt_nxt       = cnt;
      if (flush) begin
         out_valid_nxt = 1'b0;
         rem_mask_nxt  = 8'd0;
         cnt_nxt       = 3'd0;
      end else if (state == IDLE) begin
         if (accept) begin
            if (!in_is_multi) begin
               out_valid_nxt = 1'b1;
               out_instr_nxt = in_instr;
               out_pc_nxt    = in_pc;
               out_uop_nxt   = 1'b0;
               out_last_nxt  = 1'b1;
            end else if (in_mask != 8'd0) begin
               out_valid_nxt = 1'b1;
               out_instr_nxt = make_uop(in_is_sm, sel_idx, in_ra, 3'd0);
               out_pc_nxt    = in_pc;
               out_uop_nxt   = 1'b1;
               out_last_nxt  = sel_last;
               rem_mask_nxt  = in_mask & ~sel_clr;
               cnt_nxt       = 3'd1;
               base_nxt      = in_ra;
               op_is_sm_nxt  = in_is_sm;
               seq_pc_nxt    = in_pc;
            end else begin
               out_valid_nxt = 1'b0;
            end
         end else if (adv) begin
            out_valid_nxt = 1'b0;
         end
      end else if (adv) begin
         // cnt wraps to 0 after the eighth micro-op of a full mask.
         out_valid_nxt = 1'b1;
         out_instr_nxt = make_uop(op_is_sm, sel_idx, base, cnt);
         out_pc_nxt    = seq_pc;
         out_uop_nxt   = 1'b1;
         out_last_nxt  = sel_last;
         rem_mask_nxt  = rem_mask & ~sel_clr;
         cnt_nxt       = cnt + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= 16'd0;
         out_pc    <= 16'd0;
         out_uop   <= 1'b0;
         out_last  <= 1'b0;
         rem_mask  <= 8'd0;
         base      <= 3'd0;
         op_is_sm  <= 1'b0;
         seq_pc    <= 16'd0;
         cnt       <= 3'd0;
      end else begin
         out_valid <= out_valid_nxt;
         out_instr <= out_instr_nxt;
         out_pc    <= out_pc_nxt;
         out_uop   <= out_uop_nxt;
         out_last  <= out_last_nxt;
         rem_mask  <= rem_mask_nxt;
         base      <= base_nxt;
         op_is_sm  <= op_is_sm_nxt;
         seq_pc    <= seq_pc_nxt;
         cnt       <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_lm_sm_expander.sv
// Directed bench for lm_sm_expander: pass-through, LM/SM expansion, stalls, flush,
// empty mask and mid-sequence reset, each step checked with immediate assertions.
module tb_lm_sm_expander;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic        out_uop, out_last, busy;
   logic [15:0] in_instr, in_pc, out_instr, out_pc;

   int total = 0;
   int bad   = 0;

   lm_sm_expander dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_uop   (out_uop),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic [15:0] instr,
                                 input logic [15:0] pc);
      in_valid = valid;
      in_instr = instr;
      in_pc    = pc;
   endtask

   function automatic logic [15:0] sw_uop(input int k);
      logic [2:0] r;
      r = 3'(k);
      return {4'b0101, r, 3'd3, 3'b000, r};
   endfunction

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      step();
      check_output("rst_in_ready", {15'd0, in_ready}, 16'd0);
      step();
      check_output("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check_output("rst_out_instr", out_instr, 16'h0000);
      check_output("rst_busy", {15'd0, busy}, 16'd0);
      rst_n = 1'b1;
      #1;
      check_output("idle_in_ready", {15'd0, in_ready}, 16'd1);

      // Pass-through of an ordinary instruction.
      apply_stimulus(1'b1, 16'h1898, 16'h0000);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("pt_valid", {15'd0, out_valid}, 16'd1);
      check_output("pt_instr", out_instr, 16'h1898);
      check_output("pt_pc", out_pc, 16'h0000);
      check_output("pt_uop", {15'd0, out_uop}, 16'd0);
      check_output("pt_last", {15'd0, out_last}, 16'd1);

      // LM R5, mask 1000_0101 -> R0/off0, R2/off1, R7/off2.
      apply_stimulus(1'b1, 16'h6A85, 16'h0002);
      step();
      apply_stimulus(1'b1, 16'h1111, 16'h0004);
      check_output("lm0_instr", out_instr, 16'h4140);
      check_output("lm0_pc", out_pc, 16'h0002);
      check_output("lm0_uop", {15'd0, out_uop}, 16'd1);
      check_output("lm0_last", {15'd0, out_last}, 16'd0);
      check_output("lm0_busy", {15'd0, busy}, 16'd1);
      check_output("lm0_in_ready", {15'd0, in_ready}, 16'd0);
      step();
      check_output("lm1_instr", out_instr, 16'h4541);
      check_output("lm1_last", {15'd0, out_last}, 16'd0);
      check_output("lm1_in_ready", {15'd0, in_ready}, 16'd0);
      step();
      check_output("lm2_instr", out_instr, 16'h4F42);
      check_output("lm2_last", {15'd0, out_last}, 16'd1);
      check_output("lm2_busy", {15'd0, busy}, 16'd0);
      check_output("lm2_in_ready", {15'd0, in_ready}, 16'd1);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("lm_next_instr", out_instr, 16'h1111);
      check_output("lm_next_pc", out_pc, 16'h0004);
      check_output("lm_next_uop", {15'd0, out_uop}, 16'd0);

      // SM R3, mask FF, out_ready toggling: each micro-op held while stalled.
      apply_stimulus(1'b1, 16'h76FF, 16'h0006);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         check_output($sformatf("sm%0d_instr", k), out_instr, sw_uop(k));
         check_output($sformatf("sm%0d_last", k), {15'd0, out_last}, (k == 7) ? 16'd1 : 16'd0);
         out_ready = 1'b0;
         step();
         check_output($sformatf("sm%0d_hold_valid", k), {15'd0, out_valid}, 16'd1);
         check_output($sformatf("sm%0d_hold_instr", k), out_instr, sw_uop(k));
         out_ready = 1'b1;
         step();
      end
      check_output("sm_drained_valid", {15'd0, out_valid}, 16'd0);
      check_output("sm_drained_busy", {15'd0, busy}, 16'd0);

      // LM R1, mask 0F, flushed after the second micro-op.
      apply_stimulus(1'b1, 16'h620F, 16'h0008);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("fl0_instr", out_instr, 16'h4040);
      step();
      check_output("fl1_instr", out_instr, 16'h4241);
      flush = 1'b1;
      #1;
      check_output("fl_in_ready_during", {15'd0, in_ready}, 16'd0);
      step();
      flush = 1'b0;
      #1;
      check_output("fl_valid", {15'd0, out_valid}, 16'd0);
      check_output("fl_busy", {15'd0, busy}, 16'd0);
      check_output("fl_in_ready", {15'd0, in_ready}, 16'd1);
      step();
      check_output("fl_no_more_valid", {15'd0, out_valid}, 16'd0);

      // Empty-mask LM is consumed silently between two ordinary instructions.
      apply_stimulus(1'b1, 16'h1234, 16'h0010);
      step();
      check_output("mz_a_valid", {15'd0, out_valid}, 16'd1);
      apply_stimulus(1'b1, 16'h6000, 16'h0012);
      step();
      check_output("mz_lm_valid", {15'd0, out_valid}, 16'd0);
      check_output("mz_lm_busy", {15'd0, busy}, 16'd0);
      apply_stimulus(1'b1, 16'h2345, 16'h0014);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("mz_b_valid", {15'd0, out_valid}, 16'd1);
      check_output("mz_b_instr", out_instr, 16'h2345);
      check_output("mz_b_pc", out_pc, 16'h0014);

      // Reset in the middle of an LM sequence.
      apply_stimulus(1'b1, 16'h6A85, 16'h0018);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("rs_first_instr", out_instr, 16'h4140);
      rst_n = 1'b0;
      #1;
      check_output("rs_in_ready_during", {15'd0, in_ready}, 16'd0);
      step();
      check_output("rs_valid", {15'd0, out_valid}, 16'd0);
      check_output("rs_instr", out_instr, 16'h0000);
      check_output("rs_pc", out_pc, 16'h0000);
      check_output("rs_uop", {15'd0, out_uop}, 16'd0);
      check_output("rs_last", {15'd0, out_last}, 16'd0);
      check_output("rs_busy", {15'd0, busy}, 16'd0);
      rst_n = 1'b1;
      apply_stimulus(1'b1, 16'h3ABC, 16'h0020);
      step();
      apply_stimulus(1'b0, 16'h0000, 16'h0000);
      check_output("rs_pt_valid", {15'd0, out_valid}, 16'd1);
      check_output("rs_pt_instr", out_instr, 16'h3ABC);
      check_output("rs_pt_pc", out_pc, 16'h0020);
      check_output("rs_pt_last", {15'd0, out_last}, 16'd1);
      step();
      check_output("rs_pt_drained", {15'd0, out_valid}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
